// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV64 multicycle control unit: FSM states, instruction
// fields, ALU operation codes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [4:0] {
    RESET, FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, ADDR, MEM_RD,
    WB_LOAD, MEM_WR, BRANCH, LUI, JAL, HALT
  } stateT;

  typedef enum logic [3:0] {
    CL_R, CL_IMM, CL_LOAD, CL_STORE, CL_BRANCH, CL_LUI, CL_JAL, CL_EBREAK, CL_BAD
  } instrClassT;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [2:0] ALU_LOAD = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b110;

  localparam logic [1:0] MUXA_PC     = 2'b00;
  localparam logic [1:0] MUXA_A      = 2'b01;
  localparam logic [1:0] MUXA_PC_OLD = 2'b10;

  localparam logic [1:0] MUXB_B      = 2'b00;
  localparam logic [1:0] MUXB_FOUR   = 2'b01;
  localparam logic [1:0] MUXB_IMM    = 2'b10;
  localparam logic [1:0] MUXB_IMM_SH = 2'b11;

  localparam logic [2:0] WB_ALU_OUT = 3'b000;
  localparam logic [2:0] WB_MDR     = 3'b001;
  localparam logic [2:0] WB_IMM     = 3'b010;
  localparam logic [2:0] WB_PC      = 3'b011;

endpackage

// File: rtl/decod_instr.sv
// Combinational instruction classifier: opcode selects the class, funct3/funct7
// validate the encoding within that class and pick the R-type ALU operation.
module decod_instr
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output instrClassT instrClass,
  output logic [2:0] rAluOp,
  output logic       isBne,
  output logic       illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    instrClass = CL_BAD;
    rAluOp     = ALU_ADD;
    isBne      = 1'b0;
    illegal    = 1'b0;
    unique case (opcode)
      OP_R: begin
        instrClass = CL_R;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD}: rAluOp = ALU_ADD;
          {F7_SUB,  F3_ADD}: rAluOp = ALU_SUB;
          {F7_BASE, F3_AND}: rAluOp = ALU_AND;
          {F7_BASE, F3_XOR}: rAluOp = ALU_XOR;
          default:           illegal = 1'b1;
        endcase
      end
      OP_IMM: begin
        instrClass = CL_IMM;
        illegal    = (funct3 != F3_ADD);
      end
      OP_LOAD: begin
        instrClass = CL_LOAD;
        illegal    = (funct3 != F3_LD);
      end
      OP_STORE: begin
        instrClass = CL_STORE;
        illegal    = (funct3 != F3_LD);
      end
      OP_BRANCH: begin
        instrClass = CL_BRANCH;
        isBne      = (funct3 == F3_BNE);
        illegal    = (funct3 != F3_BEQ) && (funct3 != F3_BNE);
      end
      OP_LUI:    instrClass = CL_LUI;
      OP_JAL:    instrClass = CL_JAL;
      OP_SYSTEM: instrClass = CL_EBREAK;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the RV64 datapath. Outputs are decoded from the state
// register; only the branch pc_write also looks at alu_zero.
module controle_multiciclo
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 1,
  parameter int STATE_W         = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               alu_zero,
  output logic               pc_write,
  output logic               ir_write,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               sel_mem_addr,
  output logic               load_a,
  output logic               load_b,
  output logic               load_alu_out,
  output logic               load_mdr,
  output logic               reg_write,
  output logic [1:0]         sel_mux_a,
  output logic [1:0]         sel_mux_b,
  output logic [2:0]         sel_wb,
  output logic               sel_pc,
  output logic [2:0]         alu_op,
  output logic               instr_done,
  output logic               halted,
  output logic               illegal,
  output logic [STATE_W-1:0] state_out
);

  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT_CYCLES);

  stateT      state, nextState;
  logic [2:0] waitCnt;
  logic       waitDone;
  logic       illegalReg;
  logic       goIllegal;

  instrClassT instrClass;
  logic [2:0] rAluOp;
  logic       isBne;
  logic       encIllegal;

  decod_instr uDecod (
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .instrClass(instrClass),
    .rAluOp    (rAluOp),
    .isBne     (isBne),
    .illegal   (encIllegal)
  );

  assign waitDone  = (waitCnt == 3'd0);
  assign illegal   = illegalReg;
  assign state_out = STATE_W'(state);

  // The wait counter reloads whenever a memory-wait state is freshly entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state      <= RESET;
      waitCnt    <= WAIT_INIT;
      illegalReg <= 1'b0;
    end else begin
      state <= nextState;
      if ((nextState == FETCH || nextState == MEM_RD) && nextState != state)
        waitCnt <= WAIT_INIT;
      else if (nextState == state && (state == FETCH || state == MEM_RD))
        waitCnt <= waitCnt - 3'd1;
      if (goIllegal)
        illegalReg <= 1'b1;
    end
  end

  always_comb begin
    nextState    = state;
    goIllegal    = 1'b0;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    sel_mem_addr = 1'b0;
    load_a       = 1'b0;
    load_b       = 1'b0;
    load_alu_out = 1'b0;
    load_mdr     = 1'b0;
    reg_write    = 1'b0;
    sel_mux_a    = MUXA_PC;
    sel_mux_b    = MUXB_B;
    sel_wb       = WB_ALU_OUT;
    sel_pc       = 1'b0;
    alu_op       = ALU_LOAD;
    instr_done   = 1'b0;
    halted       = 1'b0;
    case (state)
      RESET: nextState = FETCH;
      FETCH: begin
        mem_rd    = 1'b1;
        sel_mux_b = MUXB_FOUR;
        alu_op    = ALU_ADD;
        if (waitDone) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          nextState = DECODE;
        end
      end
      DECODE: begin
        load_a       = 1'b1;
        load_b       = 1'b1;
        sel_mux_a    = MUXA_PC_OLD;
        sel_mux_b    = MUXB_IMM_SH;
        alu_op       = ALU_ADD;
        load_alu_out = 1'b1;
        case (instrClass)
          CL_R:              nextState = EXEC_R;
          CL_IMM:            nextState = EXEC_I;
          CL_LOAD, CL_STORE: nextState = ADDR;
          CL_BRANCH:         nextState = BRANCH;
          CL_LUI:            nextState = LUI;
          CL_JAL:            nextState = JAL;
          CL_EBREAK:         nextState = HALT;
          default: begin
            nextState = HALT;
            goIllegal = 1'b1;
          end
        endcase
      end
      EXEC_R, EXEC_I, ADDR: begin
        if (encIllegal) begin
          nextState = HALT;
          goIllegal = 1'b1;
        end else begin
          sel_mux_a    = MUXA_A;
          sel_mux_b    = (state == EXEC_R) ? MUXB_B : MUXB_IMM;
          alu_op       = (state == EXEC_R) ? rAluOp : ALU_ADD;
          load_alu_out = 1'b1;
          if (state == ADDR)
            nextState = (instrClass == CL_STORE) ? MEM_WR : MEM_RD;
          else
            nextState = WB_ALU;
        end
      end
      WB_ALU: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        nextState  = FETCH;
      end
      MEM_RD: begin
        mem_rd       = 1'b1;
        sel_mem_addr = 1'b1;
        if (waitDone) begin
          load_mdr  = 1'b1;
          nextState = WB_LOAD;
        end
      end
      WB_LOAD: begin
        reg_write  = 1'b1;
        sel_wb     = WB_MDR;
        instr_done = 1'b1;
        nextState  = FETCH;
      end
      MEM_WR: begin
        mem_wr       = 1'b1;
        sel_mem_addr = 1'b1;
        instr_done   = 1'b1;
        nextState    = FETCH;
      end
      BRANCH: begin
        if (encIllegal) begin
          nextState = HALT;
          goIllegal = 1'b1;
        end else begin
          sel_mux_a  = MUXA_A;
          sel_mux_b  = MUXB_B;
          alu_op     = ALU_SUB;
          sel_pc     = 1'b1;
          pc_write   = isBne ? ~alu_zero : alu_zero;
          instr_done = 1'b1;
          nextState  = FETCH;
        end
      end
      LUI: begin
        reg_write  = 1'b1;
        sel_wb     = WB_IMM;
        instr_done = 1'b1;
        nextState  = FETCH;
      end
      JAL: begin
        reg_write  = 1'b1;
        sel_wb     = WB_PC;
        pc_write   = 1'b1;
        sel_pc     = 1'b1;
        instr_done = 1'b1;
        nextState  = FETCH;
      end
      HALT: begin
        halted    = 1'b1;
        nextState = HALT;
      end
      default: begin
        nextState = HALT;
        goIllegal = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench: instruction-level cycle-count table, hand sequences for
// reset/halt corners, and random instructions checked against a trace model.
module tb_controle_multiciclo;
  import ctrl_pkg::*;

  localparam int MWC      = 1;
  localparam int HALT_OBS = 20;
  localparam int F        = MWC + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       alu_zero = 1'b0;

  logic       pc_write, ir_write, mem_rd, mem_wr, sel_mem_addr, load_a, load_b;
  logic       load_alu_out, load_mdr, reg_write, sel_pc, instr_done, halted, illegal;
  logic [1:0] sel_mux_a, sel_mux_b;
  logic [2:0] sel_wb, alu_op;
  logic [4:0] state_out;

  controle_multiciclo #(.MEM_WAIT_CYCLES(MWC), .STATE_W(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .pc_write(pc_write), .ir_write(ir_write), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .sel_mem_addr(sel_mem_addr), .load_a(load_a), .load_b(load_b),
    .load_alu_out(load_alu_out), .load_mdr(load_mdr), .reg_write(reg_write),
    .sel_mux_a(sel_mux_a), .sel_mux_b(sel_mux_b), .sel_wb(sel_wb), .sel_pc(sel_pc),
    .alu_op(alu_op), .instr_done(instr_done), .halted(halted), .illegal(illegal),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcW, irW, memRd, memWr, selAddr, ldA, ldB, ldAlu, ldMdr, regW;
    logic [1:0] muxA, muxB;
    logic [2:0] wb;
    logic       selPc;
    logic [2:0] aluOp;
    logic       done, hlt, ill;
    logic [4:0] st;
  } stepT;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z;
    int         cycles;
    logic       pcLast;
    logic       hlt;
    logic       ill;
  } vecT;

  stepT expQ[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic stepT dutStep();
    stepT s;
    s.pcW = pc_write;   s.irW = ir_write;     s.memRd = mem_rd;   s.memWr = mem_wr;
    s.selAddr = sel_mem_addr; s.ldA = load_a; s.ldB = load_b;     s.ldAlu = load_alu_out;
    s.ldMdr = load_mdr; s.regW = reg_write;   s.muxA = sel_mux_a; s.muxB = sel_mux_b;
    s.wb = sel_wb;      s.selPc = sel_pc;     s.aluOp = alu_op;   s.done = instr_done;
    s.hlt = halted;     s.ill = illegal;      s.st = state_out;
    return s;
  endfunction

  function automatic stepT mk(input stateT st);
    stepT s = '0;
    s.st = st;
    return s;
  endfunction

  // Expected per-cycle trace of one instruction, derived from the instruction's
  // meaning: memory waits, legality rules and what each phase must drive.
  task automatic addInstr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic z, output bit halts);
    stepT s;
    bit ill = 0;
    bit ok;
    logic [2:0] rop;
    halts = 0;
    for (int k = MWC; k >= 0; k--) begin
      s = mk(FETCH); s.memRd = 1; s.muxB = 2'b01; s.aluOp = 3'b001;
      if (k == 0) begin s.irW = 1; s.pcW = 1; end
      expQ.push_back(s);
    end
    s = mk(DECODE); s.ldA = 1; s.ldB = 1; s.muxA = 2'b10; s.muxB = 2'b11;
    s.aluOp = 3'b001; s.ldAlu = 1;
    expQ.push_back(s);
    case (op)
      7'b0110011: begin
        ok = 1; rop = 3'b000;
        case ({f7, f3})
          10'b0000000_000: rop = 3'b001;
          10'b0100000_000: rop = 3'b010;
          10'b0000000_111: rop = 3'b011;
          10'b0000000_100: rop = 3'b110;
          default:         ok = 0;
        endcase
        s = mk(EXEC_R);
        if (ok) begin
          s.muxA = 2'b01; s.aluOp = rop; s.ldAlu = 1; expQ.push_back(s);
          s = mk(WB_ALU); s.regW = 1; s.done = 1; expQ.push_back(s);
        end else begin
          expQ.push_back(s); halts = 1; ill = 1;
        end
      end
      7'b0010011: begin
        s = mk(EXEC_I);
        if (f3 == 3'b000) begin
          s.muxA = 2'b01; s.muxB = 2'b10; s.aluOp = 3'b001; s.ldAlu = 1; expQ.push_back(s);
          s = mk(WB_ALU); s.regW = 1; s.done = 1; expQ.push_back(s);
        end else begin
          expQ.push_back(s); halts = 1; ill = 1;
        end
      end
      7'b0000011, 7'b0100011: begin
        s = mk(ADDR);
        if (f3 == 3'b011) begin
          s.muxA = 2'b01; s.muxB = 2'b10; s.aluOp = 3'b001; s.ldAlu = 1; expQ.push_back(s);
          if (op == 7'b0000011) begin
            for (int k = MWC; k >= 0; k--) begin
              s = mk(MEM_RD); s.memRd = 1; s.selAddr = 1; s.ldMdr = (k == 0);
              expQ.push_back(s);
            end
            s = mk(WB_LOAD); s.regW = 1; s.wb = 3'b001; s.done = 1; expQ.push_back(s);
          end else begin
            s = mk(MEM_WR); s.memWr = 1; s.selAddr = 1; s.done = 1; expQ.push_back(s);
          end
        end else begin
          expQ.push_back(s); halts = 1; ill = 1;
        end
      end
      7'b1100011: begin
        s = mk(BRANCH);
        if (f3 == 3'b000 || f3 == 3'b001) begin
          s.muxA = 2'b01; s.aluOp = 3'b010; s.selPc = 1; s.done = 1;
          s.pcW = (f3 == 3'b000) ? z : !z;
          expQ.push_back(s);
        end else begin
          expQ.push_back(s); halts = 1; ill = 1;
        end
      end
      7'b0110111: begin
        s = mk(LUI); s.regW = 1; s.wb = 3'b010; s.done = 1; expQ.push_back(s);
      end
      7'b1101111: begin
        s = mk(JAL); s.regW = 1; s.wb = 3'b011; s.pcW = 1; s.selPc = 1; s.done = 1;
        expQ.push_back(s);
      end
      7'b1110011: halts = 1;
      default: begin halts = 1; ill = 1; end
    endcase
    if (halts)
      for (int k = 0; k < HALT_OBS; k++) begin
        s = mk(HALT); s.hlt = 1; s.ill = ill; expQ.push_back(s);
      end
  endtask

  task automatic runQueue(input string tag);
    stepT e;
    int n = 0;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      #1;
      check($sformatf("%s step%0d", tag, n), 64'(dutStep()), 64'(e));
      n++;
      @(negedge clk);
    end
  endtask

  task automatic doReset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expQ.push_back(mk(RESET));
    runQueue(tag);
  endtask

  task automatic runTrace(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic z, output bit halts);
    opcode = op; funct3 = f3; funct7 = f7; alu_zero = z;
    addInstr(op, f3, f7, z, halts);
    runQueue(tag);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecT tbl[16];
    bit  h;
    int  cnt;
    logic [6:0] op, f7;
    logic [2:0] f3;

    #1;
    check("reset_outputs", 64'(dutStep()), 64'(mk(RESET)));
    doReset("initial_reset");

    tbl = '{
      '{OP_R,      3'b000, 7'b0000000, 1'b0, F+3,   1'b0, 1'b0, 1'b0},
      '{OP_R,      3'b000, 7'b0100000, 1'b0, F+3,   1'b0, 1'b0, 1'b0},
      '{OP_R,      3'b111, 7'b0000000, 1'b0, F+3,   1'b0, 1'b0, 1'b0},
      '{OP_R,      3'b100, 7'b0000000, 1'b0, F+3,   1'b0, 1'b0, 1'b0},
      '{OP_IMM,    3'b000, 7'b1010101, 1'b0, F+3,   1'b0, 1'b0, 1'b0},
      '{OP_LOAD,   3'b011, 7'b0000000, 1'b0, 2*F+3, 1'b0, 1'b0, 1'b0},
      '{OP_STORE,  3'b011, 7'b0000000, 1'b0, F+3,   1'b0, 1'b0, 1'b0},
      '{OP_BRANCH, 3'b000, 7'b0000000, 1'b1, F+2,   1'b1, 1'b0, 1'b0},
      '{OP_BRANCH, 3'b000, 7'b0000000, 1'b0, F+2,   1'b0, 1'b0, 1'b0},
      '{OP_BRANCH, 3'b001, 7'b0000000, 1'b0, F+2,   1'b1, 1'b0, 1'b0},
      '{OP_BRANCH, 3'b001, 7'b0000000, 1'b1, F+2,   1'b0, 1'b0, 1'b0},
      '{OP_LUI,    3'b000, 7'b0000000, 1'b0, F+2,   1'b0, 1'b0, 1'b0},
      '{OP_JAL,    3'b000, 7'b0000000, 1'b0, F+2,   1'b1, 1'b0, 1'b0},
      '{OP_SYSTEM, 3'b000, 7'b0000000, 1'b0, F+2,   1'b0, 1'b1, 1'b0},
      '{7'b0000000, 3'b000, 7'b0000000, 1'b0, F+2,  1'b0, 1'b1, 1'b1},
      '{OP_R,      3'b000, 7'b0000001, 1'b0, F+3,   1'b0, 1'b1, 1'b1}
    };
    foreach (tbl[i]) begin
      doReset($sformatf("tbl%0d_reset", i));
      opcode = tbl[i].op; funct3 = tbl[i].f3; funct7 = tbl[i].f7; alu_zero = tbl[i].z;
      cnt = 1;
      #1;
      while (!(instr_done || halted) && cnt < 40) begin
        @(negedge clk);
        #1;
        cnt++;
      end
      check($sformatf("tbl%0d cycles", i), 64'(cnt), 64'(tbl[i].cycles));
      check($sformatf("tbl%0d pc_write_last", i), 64'(pc_write), 64'(tbl[i].pcLast));
      check($sformatf("tbl%0d halted", i), 64'(halted), 64'(tbl[i].hlt));
      check($sformatf("tbl%0d illegal", i), 64'(illegal), 64'(tbl[i].ill));
      @(negedge clk);
    end

    // Hand sequences: load path, illegal/ebreak halts, reset in the middle of a store.
    doReset("seq_reset");
    runTrace("ld", OP_LOAD, 3'b011, 7'b0, 1'b0, h);
    runTrace("bad_op", 7'b0000000, 3'b000, 7'b0, 1'b0, h);
    doReset("after_bad_op");
    runTrace("ebreak", OP_SYSTEM, 3'b000, 7'b0, 1'b0, h);
    doReset("after_ebreak");

    opcode = OP_STORE; funct3 = 3'b011; funct7 = '0;
    addInstr(OP_STORE, 3'b011, 7'b0, 1'b0, h);
    void'(expQ.pop_back());
    runQueue("sd_partial");
    #1;
    check("sd mem_wr before rst", 64'(mem_wr), 64'(1));
    rst = 1'b1;
    #1;
    check("rst mem_wr", 64'(mem_wr), 64'(0));
    check("rst state_out", 64'(state_out), 64'(RESET));
    doReset("sd_abort_reset");
    runTrace("add_after_abort", OP_R, 3'b000, 7'b0, 1'b0, h);

    // Randomized instruction stream checked cycle by cycle against the trace model.
    for (int i = 0; i < 300; i++) begin
      f7 = 7'b0;
      f3 = 3'b000;
      case ($urandom_range(0, 9))
        0, 9: begin
          op = OP_R;
          case ($urandom_range(0, 3))
            0: f3 = 3'b000;
            1: begin f3 = 3'b000; f7 = 7'b0100000; end
            2: f3 = 3'b111;
            default: f3 = 3'b100;
          endcase
        end
        1: op = OP_IMM;
        2: begin op = OP_LOAD;  f3 = 3'b011; end
        3: begin op = OP_STORE; f3 = 3'b011; end
        4: begin op = OP_BRANCH; f3 = 3'($urandom_range(0, 1)); end
        5: op = OP_LUI;
        6: op = OP_JAL;
        7: op = ($urandom_range(0, 3) == 0) ? OP_SYSTEM : OP_IMM;
        default: op = 7'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) begin
        f3 = 3'($urandom);
        f7 = 7'($urandom);
      end
      runTrace($sformatf("rnd%0d", i), op, f3, f7, 1'($urandom_range(0, 1)), h);
      if (h) doReset($sformatf("rnd%0d_reset", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
